// File: rtl/vga_text_fb_ctrl.sv
// vga_text_fb_ctrl: shares frame-buffer port A between CPU accesses and a clear/scroll engine
module vga_text_fb_ctrl #(
  parameter int COL_WORDS = 40,
  parameter int ROWS      = 30,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_fill,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              fb_en,
  output logic [3:0]        fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_wdata,
  input  logic [31:0]       fb_rdata
);
  typedef enum logic [2:0] {IDLE, CLR, SCR_RD, SCR_WR, SCR_FILL} state_t;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(ROWS * COL_WORDS - 1);
  localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'((ROWS - 1) * COL_WORDS - 1);
  localparam logic [ADDR_W-1:0] ROW      = ADDR_W'(COL_WORDS);
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [31:0] fill;
  logic done_q, idle, accept;
  assign idle      = state == IDLE;
  assign accept    = reset && idle && cmd_valid;
  assign cmd_ready = reset && idle;
  assign cpu_ready = reset && idle;
  assign busy      = reset && !idle;
  assign done      = reset && done_q;
  assign cpu_rdata = fb_rdata;
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    fb_en    = 1'b0;
    fb_we    = 4'h0;
    fb_addr  = ptr;
    fb_wdata = fill;
    case (state)
      IDLE: begin
        fb_en    = cpu_en;
        fb_we    = cpu_we;
        fb_addr  = cpu_addr;
        fb_wdata = cpu_wdata;
        if (cmd_valid) begin
          ptr_n   = '0;
          state_n = cmd_op == 2'b01 ? CLR : cmd_op == 2'b10 ? SCR_RD : IDLE;
        end
      end
      CLR, SCR_FILL: begin
        fb_en   = 1'b1;
        fb_we   = 4'hF;
        ptr_n   = ptr + 1'b1;
        state_n = ptr == LAST ? IDLE : state;
      end
      SCR_RD: begin
        fb_en   = 1'b1;
        fb_addr = ptr + ROW;
        state_n = SCR_WR;
      end
      SCR_WR: begin
        fb_en    = 1'b1;
        fb_we    = 4'hF;
        fb_wdata = fb_rdata;
        ptr_n    = ptr + 1'b1;
        state_n  = ptr == SCR_LAST ? SCR_FILL : SCR_RD;
      end
      default: state_n = IDLE;
    endcase
    // an asserted reset must never let a write reach the memory
    if (!reset) begin
      fb_en = 1'b0;
      fb_we = 4'h0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      done_q <= (!idle && state_n == IDLE) || (accept && cmd_op[0] == cmd_op[1]);
      if (accept) fill <= cmd_fill;
    end
  end
endmodule

// File: tb/tb_vga_text_fb_ctrl.sv
// tb_vga_text_fb_ctrl: randomized directed bench with a word-array model of the frame buffer
module tb_vga_text_fb_ctrl;
  localparam int W = 40, R = 30, N = W * R, DEPTH = 2048;
  logic clk = 0, reset = 0, cmd_valid = 0, cpu_en = 0;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_fill = 0, cpu_wdata = 0, cpu_rdata, fb_wdata, fb_rdata;
  logic [3:0] cpu_we = 0, fb_we;
  logic [10:0] cpu_addr = 0, fb_addr;
  logic cmd_ready, busy, done, cpu_ready, fb_en;
  logic [31:0] mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int total = 0, bad = 0;

  vga_text_fb_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .cpu_en(cpu_en), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (fb_en) begin
      for (int b = 0; b < 4; b++)
        if (fb_we[b]) mem[fb_addr][8*b +: 8] <= fb_wdata[8*b +: 8];
      fb_rdata <= mem[fb_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) chk(tag, mem[a], exp_mem[a]);
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d);
    cpu_en = 1; cpu_we = 4'hF; cpu_addr = 11'(a); cpu_wdata = d;
    @(posedge clk); #1;
    cpu_en = 0;
    exp_mem[a] = d;
  endtask

  task automatic cpu_read(input int a);
    cpu_en = 1; cpu_we = 4'h0; cpu_addr = 11'(a);
    @(posedge clk); #1;
    cpu_en = 0;
    #1 chk("cpu_read", cpu_rdata, exp_mem[a]);
  endtask

  task automatic model_clear(input logic [31:0] f);
    for (int a = 0; a < N; a++) exp_mem[a] = f;
  endtask

  // moves the first nwr words of the screen up one row, then fills the bottom row if complete
  task automatic model_scroll(input logic [31:0] f, input int nwr);
    for (int a = 0; a < nwr; a++) exp_mem[a] = exp_mem[a + W];
    if (nwr == N - W) for (int a = N - W; a < N; a++) exp_mem[a] = f;
  endtask

  // mode 0: plain, 1: CPU read of word 10 alongside acceptance, 2: CPU write held during busy
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] f, input int want, input int mode);
    int n;
    logic seen;
    chk("cmd_ready_before", 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_op = op; cmd_fill = f;
    if (mode == 1) begin cpu_en = 1; cpu_we = 0; cpu_addr = 10; end
    #1;
    if (mode == 1) begin
      chk("arb_cpu_ready", 32'(cpu_ready), 1);
      chk("arb_fb_addr", 32'(fb_addr), 10);
      chk("arb_fb_we", 32'(fb_we), 0);
    end
    if (op[0] == op[1]) chk("nop_fb_en_accept", 32'(fb_en), 0);
    n = 0; seen = 0;
    while (!seen && n < want + 50) begin
      @(posedge clk); #1;
      cmd_valid = 0;
      if (mode != 2) cpu_en = 0;
      n++;
      if (mode == 2 && n == 10) begin
        cpu_en = 1; cpu_we = 4'hF; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
      end
      #1;
      if (mode == 1 && n == 1) begin
        chk("arb_rdata", cpu_rdata, exp_mem[10]);
        chk("arb_busy_next", 32'(busy), 1);
      end
      seen = done;
      if (!seen) begin
        chk("busy_during", 32'(busy), 1);
        if (mode == 2 && n >= 10) chk("stall_cpu_ready", 32'(cpu_ready), 0);
      end
    end
    chk("cycles_to_done", 32'(n), 32'(want));
    chk("busy_in_done", 32'(busy), 0);
    if (op[0] == op[1]) chk("nop_fb_en_done", 32'(fb_en), 0);
    if (mode == 2) begin
      chk("stall_release", 32'(cpu_ready), 1);
      @(posedge clk); #1;
      cpu_en = 0;
    end
  endtask

  initial begin
    logic [31:0] f;
    cmd_valid = 1; cmd_op = 2'b01; cpu_en = 1; cpu_we = 4'hF;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_fb_en", 32'(fb_en), 0);
    chk("rst_fb_we", 32'(fb_we), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_busy_held", 32'(busy), 0);
    reset = 1; cmd_valid = 0; cpu_en = 0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    for (int a = 0; a < DEPTH; a++) cpu_write(a, $urandom);
    check_mem("preload_rand");
    for (int i = 0; i < 6; i++) cpu_read(int'($urandom_range(0, DEPTH - 1)));

    run_cmd(2'b00, $urandom, 1, 0);
    run_cmd(2'b11, $urandom, 1, 0);
    check_mem("nop_mem");

    run_cmd(2'b01, 32'h0720_0720, N + 1, 2);
    model_clear(32'h0720_0720);
    exp_mem[5] = 32'hDEADBEEF;
    check_mem("clear_stall_mem");

    for (int a = 0; a < DEPTH; a++) cpu_write(a, 32'(a * 3 + 5));
    run_cmd(2'b10, 32'h0, 2 * (R - 1) * W + W + 1, 1);
    model_scroll(32'h0, N - W);
    check_mem("scroll_mem");
    f = $urandom;
    run_cmd(2'b10, f, 2 * (R - 1) * W + W + 1, 0);
    model_scroll(f, N - W);
    check_mem("scroll_b2b_mem");
    f = $urandom;
    run_cmd(2'b01, f, N + 1, 0);
    model_clear(f);
    check_mem("clear_b2b_mem");

    for (int a = 0; a < DEPTH; a++) cpu_write(a, $urandom);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_op = 2'b10; cmd_fill = $urandom;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (99) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("mid_rst_busy_now", 32'(busy), 0);
    chk("mid_rst_fb_en_now", 32'(fb_en), 0);
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_fb_en", 32'(fb_en), 0);
    chk("mid_rst_done", 32'(done), 0);
    reset = 1;
    #1;
    chk("mid_rst_release_ready", 32'(cmd_ready), 1);
    chk("mid_rst_release_done", 32'(done), 0);
    model_scroll(32'h0, 49);
    check_mem("mid_rst_partial");
    f = $urandom;
    run_cmd(2'b01, f, N + 1, 0);
    model_clear(f);
    check_mem("clear_after_rst");
    for (int i = 0; i < 6; i++) cpu_read(int'($urandom_range(0, DEPTH - 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
